// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit: one aligned word-bus transaction per load/store
// Alignment is checked at capture; misaligned accesses bypass the bus and complete with err.
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] rs2_rd_data_i,
  input  logic            inst_lb_i,
  input  logic            inst_lh_i,
  input  logic            inst_lw_i,
  input  logic            inst_lbu_i,
  input  logic            inst_lhu_i,
  input  logic            inst_sb_i,
  input  logic            inst_sh_i,
  input  logic            inst_sw_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            rd_wr_en_o,
  output logic [XLEN-1:0] rd_wr_data_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [3:0]      dbus_be_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t          state_q, state_d;
  size_t           size_q, size_d;
  logic            sign_q, sign_d;
  logic            load_q, load_d;
  logic            err_q, err_d;
  logic [1:0]      off_q, off_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic [7:0]      strobes;
  logic            is_store, is_half, is_word, misaligned;
  logic [3:0]      be_calc;
  logic [XLEN-1:0] wdata_calc;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;

  assign strobes  = {inst_lb_i, inst_lh_i, inst_lw_i, inst_lbu_i,
                     inst_lhu_i, inst_sb_i, inst_sh_i, inst_sw_i};
  assign is_store = inst_sb_i | inst_sh_i | inst_sw_i;
  assign is_half  = inst_lh_i | inst_lhu_i | inst_sh_i;
  assign is_word  = inst_lw_i | inst_sw_i;
  assign misaligned = (is_half & addr_i[0]) | (is_word & (|addr_i[1:0]));

  always_comb begin
    be_calc    = 4'b0001 << addr_i[1:0];
    wdata_calc = {4{rs2_rd_data_i[7:0]}};
    if (is_half) begin
      be_calc    = addr_i[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {2{rs2_rd_data_i[15:0]}};
    end else if (is_word) begin
      be_calc    = 4'b1111;
      wdata_calc = rs2_rd_data_i;
    end
  end

  // Lane extraction uses the offset captured at start, not the live address.
  assign byte_sel = dbus_rdata_i[{off_q, 3'b000} +: 8];
  assign half_sel = off_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];

  always_comb begin
    case (size_q)
      SZ_B:    load_data = {{(XLEN-8){sign_q & byte_sel[7]}}, byte_sel};
      SZ_H:    load_data = {{(XLEN-16){sign_q & half_sel[15]}}, half_sel};
      default: load_data = dbus_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    sign_d  = sign_q;
    load_d  = load_q;
    err_d   = err_q;
    off_d   = off_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (start_i && $onehot(strobes)) begin
          size_d = is_word ? SZ_W : (is_half ? SZ_H : SZ_B);
          sign_d = inst_lb_i | inst_lh_i;
          load_d = ~is_store;
          err_d  = misaligned;
          off_d  = addr_i[1:0];
          if (misaligned) begin
            state_d = RESP;
          end else begin
            // Bus payload only changes for accesses that will actually use the bus.
            state_d = REQ;
            we_d    = is_store;
            addr_d  = {addr_i[XLEN-1:2], 2'b00};
            be_d    = be_calc;
            wdata_d = wdata_calc;
          end
        end
      end
      REQ: begin
        if (dbus_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (dbus_rvalid_i) begin
          state_d = RESP;
          if (load_q) rdata_d = load_data;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      size_q  <= SZ_B;
      sign_q  <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      load_q  <= load_d;
      err_q   <= err_d;
      off_q   <= off_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == RESP);
  assign err_o        = (state_q == RESP) & err_q;
  assign rd_wr_en_o   = (state_q == RESP) & load_q & ~err_q;
  assign rd_wr_data_o = rdata_q;
  assign dbus_req_o   = (state_q == REQ);
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = wdata_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core. It receives the effective address computed by the ALU adder (rs1 + imm) together with the decoded load/store strobes. It runs one aligned word-bus transaction per instruction and returns the sign- or zero-extended load result for write-back to the register file. It sits between the ALU and the data bus and is the consumer of the address path that the ALU produces but does not write back.

## Interface
- XLEN, 32, data/address width; only 32 is supported

- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle request; the address, store data and strobes are valid in this cycle
- addr_i  in  XLEN  effective byte address (ALU add result)
- rs2_rd_data_i  in  XLEN  store data
- inst_lb_i, inst_lh_i, inst_lw_i, inst_lbu_i, inst_lhu_i, inst_sb_i, inst_sh_i, inst_sw_i  in  1 each  decoded strobes; at most one is high
- busy_o  out  1  a transaction is in progress
- done_o  out  1  one-cycle completion pulse, for both success and error
- err_o  out  1  one-cycle pulse with done_o on a misaligned access
- rd_wr_en_o  out  1  one-cycle load write-back strobe
- rd_wr_data_o  out  XLEN  load result; holds until the next successful load
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = store
- dbus_addr_o  out  XLEN  word-aligned address, {addr[31:2], 2'b00}
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  XLEN  lane-replicated store data
- dbus_gnt_i  in  1  request accepted
- dbus_rvalid_i  in  1  response valid; sent for loads and stores
- dbus_rdata_i  in  XLEN  read word

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - start_i with exactly one strobe high captures the address, store data, access size, sign mode and direction.
  - start_i with no strobe, or start_i while busy, is ignored.
- Alignment check is done at capture:
  - halfword (lh/lhu/sh): addr[0] must be 0.
  - word (lw/sw): addr[1:0] must be 0.
  - byte accesses are never misaligned.
- Misaligned access: go to RESP with the error flag set. No bus request is made and rd_wr_en_o stays low.
- Aligned access: go to REQ.
- REQ:
  - dbus_req_o = 1; address, we, be and wdata are held stable.
  - On gnt, go to WAIT.
- WAIT:
  - dbus_rvalid_i = 1 moves to RESP.
  - On a load, the extracted and extended data is registered into rd_wr_data_o at the same time.
  - rvalid outside WAIT is ignored.
- RESP:
  - done_o = 1 for one cycle.
  - rd_wr_en_o = 1 for a successful load.
  - err_o = 1 for a misaligned access.
  - Next state is IDLE.
- Byte enables and store data:
  - sb: be = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}
  - sh: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2[15:0]}}
  - sw: be = 4'b1111; wdata = rs2
  - Loads drive the same be pattern.
- Load extraction:
  - Select the byte at rdata[8*addr[1:0] +: 8] or the halfword at rdata[16*addr[1] +: 16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- busy_o = (state != IDLE).

## Timing
- Reset values:
  - state = IDLE.
  - busy_o, done_o, err_o, rd_wr_en_o, dbus_req_o, dbus_we_o = 0.
  - dbus_addr_o, dbus_wdata_o, rd_wr_data_o = 0; dbus_be_o = 4'b0000.
- Outputs are registered or state-decoded; there is no combinational path from an input to dbus_req_o.
- Minimum aligned transaction:
  - start in cycle 0; req in cycle 1 with gnt in cycle 1; rvalid in cycle 2; done/rd_wr_en in cycle 3.
  - The next start is accepted in cycle 4.
- Gnt stall: req stays high with all payload stable for any number of cycles.
- Rvalid stall: WAIT for any number of cycles; there is no timeout.
- A gnt and rvalid in the same cycle while in REQ: only the gnt counts; the rvalid is ignored.
- Misaligned access: start in cycle 0 → done/err in cycle 1; the bus stays idle.
- Reset asserted mid-transaction: the unit returns to IDLE immediately, drops req and emits no done. A bus response after reset is ignored.

## Test plan
- lw at 0x100, gnt same cycle, rdata 0xDEADBEEF → dbus_addr 0x100, be 1111, done at cycle 3, rd_wr_en=1, rd_wr_data 0xDEADBEEF.
- lb at 0x203 and lbu at 0x203 with rdata 0x80123456 → 0xFFFFFF80 and 0x00000080 respectively.
- sh at 0x302 with rs2 0x0000ABCD → we=1, be 1100, wdata 0xABCDABCD, addr 0x300, done with rd_wr_en=0.
- lw at 0x101, then sh at 0x301 → done+err the cycle after start, no req asserted, rd_wr_data unchanged.
- gnt held low for 5 cycles and rvalid 3 cycles later, start pulsed while busy → payload stable, the extra start is ignored, exactly one done.
- rst_n_i pulsed low during WAIT → all outputs at reset values, no done, the next lw completes normally.
